proc_ctrl_fsm: RTL
==================

# proc_ctrl_fsm

Multi-cycle control sequencer for the processor datapath. It walks each instruction through fetch, decode, execute, memory and writeback. It drives the IR-to-register-bank selects: the 4-bit destination-register mux (AR vs T type) and the 32-bit constant/register operand mux. It also drives PC, IR, memory and register-bank strobes. It sits between the instruction register and the datapath muxes, register bank, ALU and memory port.

## Interface
- MAX_WAIT, default 15: maximum consecutive cycles without mem_ready in FETCH or MEM before a bus fault.
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin or resume execution; honoured only in IDLE or HALT.
- ir  in  32  current IR contents; opcode = ir[31:28].
- mem_ready  in  1  memory completes the current request this cycle.
- alu_zero  in  1  ALU zero flag, sampled in EXEC for BEQ.
- ir_load  out  1  load IR from the memory data bus.
- pc_inc  out  1  PC += 1.
- pc_load  out  1  PC <= branch/jump target.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write (valid with mem_req).
- dest_sel  out  1  destination mux select: 0 = ir[27:24] (AR), 1 = ir[23:20] (T).
- const_sel  out  1  operand mux select: 0 = register operand, 1 = immediate.
- rb_we  out  1  register bank write enable.
- alu_op  out  3  ALU function.
- state  out  3  current state encoding (debug).
- halted  out  1  high in HALT.
- fault  out  1  high in FAULT.

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7.
- Opcode classes:
  - 0000–0111 AR, alu_op = opcode[2:0].
  - 1000 LDI (T type).
  - 1001 LD, 1010 ST, 1011 BEQ, 1100 JMP, 1111 HALT.
  - 1101 and 1110 are illegal.
- IDLE: all outputs 0. start=1 -> FETCH.
- FETCH: mem_req=1, mem_we=0. ir_load = pc_inc = mem_ready (combinational, Mealy).
  - mem_ready=1 -> DECODE.
  - Otherwise wait; timeout -> FAULT.
- DECODE: latch the class and alu_op from ir into internal registers.
  - HALT -> HALT; illegal -> FAULT; else -> EXEC.
- EXEC:
  - AR: dest_sel=0, const_sel=0 -> WB.
  - LDI: dest_sel=1, const_sel=1, alu_op=000 (pass) -> WB.
  - LD/ST: const_sel=1 (address offset) -> MEM.
  - BEQ: pc_load=alu_zero -> FETCH.
  - JMP: pc_load=1 -> FETCH.
- MEM: mem_req=1, mem_we=1 for ST. On mem_ready: ST -> FETCH, LD -> WB (dest_sel=1). Timeout -> FAULT.
- WB: rb_we=1 for exactly one cycle -> FETCH.
- Select stability: dest_sel, const_sel and alu_op come from the latched class and hold constant from EXEC through WB. They are 0 in IDLE/FETCH/DECODE/HALT/FAULT.
- HALT: halted=1. start -> FETCH (PC unchanged, so the next instruction is fetched).
- FAULT: fault=1, all strobes 0. Sticky until rst_n.
- Wait counter: width ceil(log2(MAX_WAIT+1)); cleared on entry to FETCH/MEM; increments each cycle mem_ready=0.
  - Counter == MAX_WAIT with mem_ready=0 -> FAULT next edge.
  - mem_ready=1 in that same cycle wins.
- Ignored inputs: start outside IDLE/HALT; mem_ready outside FETCH/MEM.

## Timing
- Reset: state=IDLE. All outputs 0, counter 0, latched class 0.
- rst_n low mid-instruction aborts immediately. rb_we, mem_req and pc_load drop asynchronously; no partial writeback.
- Latency with zero-wait memory:
  - AR/LDI: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LD: 5 cycles.
  - ST: 4 cycles.
  - BEQ/JMP: 3 cycles.
  - Each wait cycle adds 1.
- ir is read in DECODE, one cycle after ir_load; the IR register is updated on that same edge.
- Strobe widths: rb_we, pc_load, ir_load and pc_inc are single-cycle pulses per instruction.
- mem_req stays high continuously until the mem_ready cycle inclusive.

## Test plan
- Reset, start=1, ir=0x3_1_2_00005 (AR, op 011), mem_ready=1 always -> states 0,1,2,3,5,1. In EXEC/WB: dest_sel=0, const_sel=0, alu_op=011. rb_we high only in WB.
- LDI ir=0x8_0_7_0000A, then LD with mem_ready delayed 3 cycles -> LDI: dest_sel=1, const_sel=1 in EXEC/WB. LD: mem_req high 4 cycles in MEM, rb_we one cycle after mem_ready.
- BEQ with alu_zero=1 and then alu_zero=0 -> pc_load pulses only in the first case; both return to FETCH 3 cycles after FETCH entry.
- mem_ready held 0 in FETCH with MAX_WAIT=15 -> FAULT entered after 16 FETCH cycles. fault=1 sticky through start pulses; cleared only by rst_n. Same run with mem_ready=1 on the 16th cycle -> DECODE.
- ir opcode 1111 -> HALT with halted=1. start ignored until HALT; start in HALT -> FETCH. Opcode 1101 -> FAULT.
- Assert rst_n low during WB of an AR instruction -> rb_we falls without a clock edge; state=0 and all outputs 0 after release.

Source files
------------

// File: rtl/proc_ctrl_fsm_if.sv
// Control bundle between the instruction sequencer and the datapath.
// master = sequencer side, slave = datapath / IR / memory side.
interface proc_ctrl_fsm_if;
  logic        start;
  logic [31:0] ir;
  logic        mem_ready;
  logic        alu_zero;
  logic        ir_load;
  logic        pc_inc;
  logic        pc_load;
  logic        mem_req;
  logic        mem_we;
  logic        dest_sel;
  logic        const_sel;
  logic        rb_we;
  logic [2:0]  alu_op;
  logic [2:0]  state;
  logic        halted;
  logic        fault;

  modport master (
    input  start, ir, mem_ready, alu_zero,
    output ir_load, pc_inc, pc_load, mem_req, mem_we, dest_sel, const_sel, rb_we,
    output alu_op, state, halted, fault
  );

  modport slave (
    output start, ir, mem_ready, alu_zero,
    input  ir_load, pc_inc, pc_load, mem_req, mem_we, dest_sel, const_sel, rb_we,
    input  alu_op, state, halted, fault
  );
endinterface

// File: rtl/proc_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer driving PC, IR,
// memory and register-bank strobes plus the destination and operand mux selects.
module proc_ctrl_fsm #(
  parameter int unsigned MAX_WAIT = 15
) (
  input logic            clk,
  input logic            rst_n,
  proc_ctrl_fsm_if.master bus
);

  localparam int unsigned CntW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6,
    StFault  = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    ClsAr   = 3'd0,
    ClsLdi  = 3'd1,
    ClsLd   = 3'd2,
    ClsSt   = 3'd3,
    ClsBeq  = 3'd4,
    ClsJmp  = 3'd5,
    ClsHalt = 3'd6,
    ClsIll  = 3'd7
  } class_e;

  state_e          state_q, state_d;
  class_e          cls_q, cls_d;
  logic [2:0]      op_q, op_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  class_e          dec_cls;
  logic            wait_max;

  // Only the opcode nibble steers the sequencer; operand fields go to the datapath.
  logic unused_ir;
  assign unused_ir = ^bus.ir[27:0];

  always_comb begin
    dec_cls = ClsIll;
    if (!bus.ir[31]) begin
      dec_cls = ClsAr;
    end else begin
      case (bus.ir[30:28])
        3'b000:  dec_cls = ClsLdi;
        3'b001:  dec_cls = ClsLd;
        3'b010:  dec_cls = ClsSt;
        3'b011:  dec_cls = ClsBeq;
        3'b100:  dec_cls = ClsJmp;
        3'b111:  dec_cls = ClsHalt;
        default: dec_cls = ClsIll;
      endcase
    end
  end

  assign wait_max = (cnt_q == CntW'(MAX_WAIT));

  always_comb begin
    state_d       = state_q;
    cls_d         = cls_q;
    op_d          = op_q;
    cnt_d         = cnt_q;
    bus.ir_load   = 1'b0;
    bus.pc_inc    = 1'b0;
    bus.pc_load   = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.dest_sel  = 1'b0;
    bus.const_sel = 1'b0;
    bus.rb_we     = 1'b0;
    bus.alu_op    = 3'b000;
    bus.halted    = 1'b0;
    bus.fault     = 1'b0;

    // Selects derive only from the latched class, so they cannot glitch EXEC..WB.
    if (state_q inside {StExec, StMem, StWb}) begin
      bus.dest_sel  = cls_q inside {ClsLdi, ClsLd};
      bus.const_sel = cls_q inside {ClsLdi, ClsLd, ClsSt};
      bus.alu_op    = op_q;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.start) state_d = StFetch;
      end
      StFetch: begin
        bus.mem_req = 1'b1;
        bus.ir_load = bus.mem_ready;
        bus.pc_inc  = bus.mem_ready;
        if (bus.mem_ready)  state_d = StDecode;
        else if (wait_max)  state_d = StFault;
        else                cnt_d   = cnt_q + CntW'(1);
      end
      StDecode: begin
        cls_d = dec_cls;
        op_d  = (dec_cls == ClsAr) ? bus.ir[30:28] : 3'b000;
        if (dec_cls == ClsHalt)     state_d = StHalt;
        else if (dec_cls == ClsIll) state_d = StFault;
        else                        state_d = StExec;
      end
      StExec: begin
        case (cls_q)
          ClsAr, ClsLdi: state_d = StWb;
          ClsLd, ClsSt:  state_d = StMem;
          ClsBeq: begin
            bus.pc_load = bus.alu_zero;
            state_d     = StFetch;
          end
          ClsJmp: begin
            bus.pc_load = 1'b1;
            state_d     = StFetch;
          end
          default: state_d = StFault;
        endcase
      end
      StMem: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = (cls_q == ClsSt);
        if (bus.mem_ready)  state_d = (cls_q == ClsSt) ? StFetch : StWb;
        else if (wait_max)  state_d = StFault;
        else                cnt_d   = cnt_q + CntW'(1);
      end
      StWb: begin
        bus.rb_we = 1'b1;
        state_d   = StFetch;
      end
      StHalt: begin
        bus.halted = 1'b1;
        if (bus.start) state_d = StFetch;
      end
      StFault: begin
        bus.fault = 1'b1;
      end
    endcase

    // Every state change restarts the wait count for the next FETCH/MEM.
    if (state_d != state_q) cnt_d = '0;
  end

  assign bus.state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cls_q   <= ClsAr;
      op_q    <= 3'b000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
